// File: rtl/control_fsm.sv
// Multi-cycle RV32 subset control FSM: sequences fetch, decode, execute,
// memory and writeback phases and drives the datapath strobes.
// Ports: clk, reset (sync, active-high); Instruction_i, Zero_i, Mem_Ready_i in;
// ALU/mux selects, memory/IR/PC/RF strobes, Fault_o, State_o out.
module control_fsm #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instruction_i,
    input  logic        Zero_i,
    input  logic        Mem_Ready_i,
    output logic [3:0]  ALU_Operation_o,
    output logic [1:0]  ALU_Src_A_o,
    output logic [1:0]  ALU_Src_B_o,
    output logic        Mem_Req_o,
    output logic        Mem_Write_o,
    output logic        I_or_D_o,
    output logic        IR_Write_o,
    output logic        PC_Write_o,
    output logic        PC_Src_o,
    output logic        Reg_Write_o,
    output logic [1:0]  Mem_to_Reg_o,
    output logic        Fault_o,
    output logic [3:0]  State_o
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        EXEC_R = 4'd2,
        EXEC_I = 4'd3,
        ADDR   = 4'd4,
        MEM_RD = 4'd5,
        MEM_WB = 4'd6,
        MEM_WR = 4'd7,
        ALU_WB = 4'd8,
        BRANCH = 4'd9,
        JAL    = 4'd10,
        FAULT  = 4'd15
    } state_t;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_LUI = 4'b0010;

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_LUI = 7'b0110111;
    localparam logic [6:0] OPC_LD  = 7'b0000011;
    localparam logic [6:0] OPC_ST  = 7'b0100011;
    localparam logic [6:0] OPC_BR  = 7'b1100011;
    localparam logic [6:0] OPC_JAL = 7'b1101111;

    localparam int CW = $clog2(WAIT_LIMIT + 1);

    state_t        state_q;
    state_t        state_d;
    state_t        dec_next;
    logic [CW-1:0] wait_q;
    logic          wait_hit;

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       is_r;
    logic       is_i;
    logic       is_lui;
    logic       is_ld;
    logic       is_st;
    logic       is_beq;
    logic       is_jal;

    assign opc = Instruction_i[6:0];
    assign f3  = Instruction_i[14:12];
    assign f7  = Instruction_i[31:25];

    assign is_r   = (opc == OPC_R) && (f3 == 3'b000) &&
                    ((f7 == 7'b0000000) || (f7 == 7'b0100000));
    assign is_i   = (opc == OPC_I) && (f3 == 3'b000);
    assign is_lui = (opc == OPC_LUI);
    assign is_ld  = (opc == OPC_LD) && (f3 == 3'b010);
    assign is_st  = (opc == OPC_ST) && (f3 == 3'b010);
    assign is_beq = (opc == OPC_BR) && (f3 == 3'b000);
    assign is_jal = (opc == OPC_JAL);

    // This cycle would be the WAIT_LIMIT-th consecutive unanswered request.
    assign wait_hit = (wait_q == CW'(WAIT_LIMIT - 1));

    always_comb begin
        dec_next = FAULT;
        unique case (1'b1)
            is_r:           dec_next = EXEC_R;
            is_i, is_lui:   dec_next = EXEC_I;
            is_ld, is_st:   dec_next = ADDR;
            is_beq:         dec_next = BRANCH;
            is_jal:         dec_next = JAL;
            default:        dec_next = FAULT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            // Staying put while requesting means memory did not answer.
            if ((state_d != state_q) || !Mem_Req_o)
                wait_q <= '0;
            else
                wait_q <= wait_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: begin
                if (Mem_Ready_i)   state_d = DECODE;
                else if (wait_hit) state_d = FAULT;
            end
            DECODE: state_d = dec_next;
            EXEC_R: state_d = ALU_WB;
            EXEC_I: state_d = ALU_WB;
            ALU_WB: state_d = FETCH;
            ADDR:   state_d = (opc == OPC_LD) ? MEM_RD : MEM_WR;
            MEM_RD: begin
                if (Mem_Ready_i)   state_d = MEM_WB;
                else if (wait_hit) state_d = FAULT;
            end
            MEM_WB: state_d = FETCH;
            MEM_WR: begin
                if (Mem_Ready_i)   state_d = FETCH;
                else if (wait_hit) state_d = FAULT;
            end
            BRANCH: state_d = FETCH;
            JAL:    state_d = FETCH;
            FAULT:  state_d = FAULT;
            default: state_d = FAULT;
        endcase
    end

    always_comb begin
        ALU_Operation_o = OP_ADD;
        ALU_Src_A_o     = 2'b00;
        ALU_Src_B_o     = 2'b00;
        Mem_Req_o       = 1'b0;
        Mem_Write_o     = 1'b0;
        I_or_D_o        = 1'b0;
        IR_Write_o      = 1'b0;
        PC_Write_o      = 1'b0;
        PC_Src_o        = 1'b0;
        Reg_Write_o     = 1'b0;
        Mem_to_Reg_o    = 2'b00;
        Fault_o         = 1'b0;
        case (state_q)
            FETCH: begin
                Mem_Req_o = 1'b1;
                if (Mem_Ready_i) begin
                    IR_Write_o  = 1'b1;
                    PC_Write_o  = 1'b1;
                    ALU_Src_B_o = 2'b01;
                end
            end
            DECODE: begin
                ALU_Src_A_o = 2'b01;
                ALU_Src_B_o = 2'b10;
            end
            EXEC_R: begin
                ALU_Src_A_o = 2'b10;
                if (f7 == 7'b0100000) ALU_Operation_o = OP_SUB;
            end
            EXEC_I: begin
                ALU_Src_B_o = 2'b10;
                if (opc == OPC_LUI) ALU_Operation_o = OP_LUI;
                else                ALU_Src_A_o = 2'b10;
            end
            ALU_WB: Reg_Write_o = 1'b1;
            ADDR: begin
                ALU_Src_A_o = 2'b10;
                ALU_Src_B_o = 2'b10;
            end
            MEM_RD: begin
                Mem_Req_o = 1'b1;
                I_or_D_o  = 1'b1;
            end
            MEM_WB: begin
                Reg_Write_o  = 1'b1;
                Mem_to_Reg_o = 2'b01;
            end
            MEM_WR: begin
                Mem_Req_o   = 1'b1;
                Mem_Write_o = 1'b1;
                I_or_D_o    = 1'b1;
            end
            BRANCH: begin
                ALU_Src_A_o     = 2'b10;
                ALU_Operation_o = OP_SUB;
                PC_Src_o        = 1'b1;
                PC_Write_o      = Zero_i;
            end
            JAL: begin
                Reg_Write_o  = 1'b1;
                Mem_to_Reg_o = 2'b10;
                PC_Write_o   = 1'b1;
                PC_Src_o     = 1'b1;
            end
            FAULT: Fault_o = 1'b1;
            default: Fault_o = 1'b0;
        endcase
    end

    assign State_o = state_q;

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 Parameter WAIT_LIMIT, default 15: max consecutive cycles a memory request may wait for Mem_Ready_i before FAULT.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 Instruction_i  in  32  current instruction (instruction-register output).
REQ-005 Zero_i  in  1  ALU zero flag.
REQ-006 Mem_Ready_i  in  1  memory completion strobe; meaningful only while Mem_Req_o=1.
REQ-007 ALU_Operation_o  out  4  ALU op: ADD=4'b0000, SUB=4'b0001, LUI=4'b0010.
REQ-008 ALU_Src_A_o  out  2  00 PC, 01 old PC, 10 rs1.
REQ-009 ALU_Src_B_o  out  2  00 rs2, 01 constant 4, 10 immediate.
REQ-010 Mem_Req_o, Mem_Write_o, I_or_D_o  out  1 each  memory request, write enable, address select (0 PC, 1 ALUOut).
REQ-011 IR_Write_o, PC_Write_o, PC_Src_o  out  1 each  IR load, PC load, PC source (0 ALU result, 1 ALUOut register).
REQ-012 Reg_Write_o  out  1; Mem_to_Reg_o  out  2  writeback source: 00 ALUOut, 01 memory data, 10 PC.
REQ-013 Fault_o  out  1  sticky fault; State_o  out  4  current state encoding.

Function
REQ-014 States/encodings SHALL be: FETCH 0, DECODE 1, EXEC_R 2, EXEC_I 3, ADDR 4, MEM_RD 5, MEM_WB 6, MEM_WR 7, ALU_WB 8, BRANCH 9, JAL 10, FAULT 15; other codes -> FAULT next cycle.
REQ-015 Outputs not listed for a state SHALL be 0, except ALU_Operation_o defaults to ADD.
REQ-016 FETCH: Mem_Req_o=1, I_or_D_o=0; in cycle where Mem_Ready_i=1: IR_Write_o=1, PC_Write_o=1, PC_Src_o=0, A=PC, B=4, ADD, next DECODE; otherwise stay.
REQ-017 DECODE: A=old PC, B=imm, ADD (branch/jump target); next state per opcode Instruction_i[6:0] below.
REQ-018 0110011 with funct3=000 and funct7=0000000 or 0100000 -> EXEC_R; 0010011 funct3=000 -> EXEC_I; 0110111 -> EXEC_I; 0000011 funct3=010 or 0100011 funct3=010 -> ADDR; 1100011 funct3=000 -> BRANCH; 1101111 -> JAL; anything else -> FAULT.
REQ-019 EXEC_R: A=rs1, B=rs2; op SUB if funct7=0100000 else ADD; next ALU_WB.
REQ-020 EXEC_I: B=imm; op LUI if opcode 0110111 else ADD with A=rs1; next ALU_WB.
REQ-021 ALU_WB: Reg_Write_o=1, Mem_to_Reg_o=00; next FETCH.
REQ-022 ADDR: A=rs1, B=imm, ADD; next MEM_RD for loads, MEM_WR for stores.
REQ-023 MEM_RD: Mem_Req_o=1, I_or_D_o=1; on Mem_Ready_i=1 -> MEM_WB. MEM_WB: Reg_Write_o=1, Mem_to_Reg_o=01; next FETCH.
REQ-024 MEM_WR: Mem_Req_o=1, Mem_Write_o=1, I_or_D_o=1; on Mem_Ready_i=1 -> FETCH.
REQ-025 BRANCH: A=rs1, B=rs2, SUB, PC_Src_o=1, PC_Write_o=Zero_i (same cycle, combinational); next FETCH.
REQ-026 JAL: Reg_Write_o=1, Mem_to_Reg_o=10, PC_Write_o=1, PC_Src_o=1; next FETCH.
REQ-027 Wait counter SHALL count consecutive Mem_Req_o=1 cycles with Mem_Ready_i=0, clear on any state change; when count reaches WAIT_LIMIT with no ready -> FAULT.
REQ-028 Mem_Ready_i=1 and counter hitting WAIT_LIMIT in same cycle: ready wins (normal transition).
REQ-029 Mem_Ready_i SHALL be ignored in states without Mem_Req_o.
REQ-030 FAULT: Fault_o=1, all strobes 0, held until reset.
REQ-031 Latencies with zero-wait memory: R/I/LUI 4 cycles, lw 5, sw 4, beq 3, jal 3.

Reset
REQ-032 reset=1 at a rising edge SHALL force FETCH, wait counter 0, Fault_o=0 next cycle, overriding any transition, including mid memory wait and FAULT.
REQ-033 After reset, FETCH outputs (Mem_Req_o=1, I_or_D_o=0, others 0, op ADD) SHALL appear from the first post-reset cycle.

Verification
REQ-034 add x3,x1,x2 (0x002081B3), ready same cycle -> states 0,1,2,8,0; Reg_Write_o=1 only in ALU_WB; op ADD.
REQ-035 sub (0x402081B3) -> EXEC_R shows ALU_Operation_o=4'b0001; lui (0x123450B7) -> EXEC_I shows 4'b0010, B=10.
REQ-036 lw with Mem_Ready_i low 3 cycles in MEM_RD -> stays MEM_RD 4 cycles, then MEM_WB with Mem_to_Reg_o=01.
REQ-037 beq: Zero_i=1 -> PC_Write_o=1, PC_Src_o=1 in BRANCH; Zero_i=0 -> PC_Write_o=0.
REQ-038 Opcode 0x7F, or Mem_Ready_i held low 15 cycles in FETCH -> FAULT, Fault_o=1 sticky; reset -> FETCH, Fault_o=0.
REQ-039 reset asserted during MEM_WR wait -> next cycle FETCH, Mem_Write_o=0.
